// File: rtl/instr_fetch.sv
// Purpose : instruction fetch unit. Walks pc through a 512-word instruction
//           memory, presents each fetched word to the decoder through a
//           one-entry register (line_data / instr_valid), redirects on a
//           resolved branch, and parks in HALT when it fetches a halt opcode.
// Ports   : clk, rst (async active-low) | stall (decoder backpressure)
//           branch_taken, branch_addr (redirect) | mem_req, mem_addr,
//           mem_rdata, mem_ready (memory read port) | line_data, instr_valid,
//           pc, halted (decoder / status outputs).
// Latency : a word seen with mem_ready is on line_data one edge later; with
//           zero-wait memory and no stall the unit sustains one word/cycle.
module instr_fetch #(
    parameter logic [8:0] RESET_PC    = 9'd0,
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [8:0]  branch_addr,
    output logic        mem_req,
    output logic [8:0]  mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] line_data,
    output logic        instr_valid,
    output logic [8:0]  pc,
    output logic        halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  pc_q, pc_d;
    logic [15:0] line_q, line_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic        slot_free;
    logic        capture;
    logic        consume;
    logic        is_halt_word;

    // The output register can take a new word if it is empty or is being
    // drained by the decoder this very cycle.
    assign slot_free = !valid_q || !stall;

    // Gated by rst so that the request is forced low while reset is held,
    // independent of the register values. Dropping the request also cancels
    // any read still in flight; the memory must discard it.
    assign mem_req = rst && (state_q == FETCH) && slot_free && !branch_taken;

    // Only one address is ever presented, so at most one read is outstanding.
    assign mem_addr = pc_q;

    // A mem_ready without a live request is ignored.
    assign capture      = mem_req && mem_ready;
    assign consume      = valid_q && !stall;
    assign is_halt_word = (mem_rdata[15:10] == HALT_OPCODE);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        line_d   = line_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        if (branch_taken) begin
            // Redirect wins over everything; any word returned this cycle is
            // dropped because mem_req is already low.
            state_d  = FETCH;
            pc_d     = branch_addr;
            line_d   = 16'h0000;
            valid_d  = 1'b0;
            halted_d = 1'b0;
        end else if (capture) begin
            if (is_halt_word) begin
                // Halt word is swallowed: pc stays on it, line_data keeps the
                // last real instruction, and nothing is shown to the decoder.
                // A capture implies slot_free, so any valid word was consumed.
                state_d  = HALT;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end else begin
                line_d  = mem_rdata;
                valid_d = 1'b1;
                pc_d    = pc_q + 9'd1;   // natural 9-bit wrap 511 -> 0
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            line_q   <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            line_q   <= line_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign line_data   = line_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [8:0]  branch_addr;
    logic        mem_req;
    logic [8:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] line_data;
    logic        instr_valid;
    logic [8:0]  pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // memory model: ready after lat cycles of a held request; force_ready
    // injects a completion regardless of mem_req
    logic [15:0] mem [0:511];
    int          lat;
    int          wait_cnt;
    logic        force_ready;

    instr_fetch dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .line_data(line_data), .instr_valid(instr_valid),
        .pc(pc), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = force_ready || (mem_req && (wait_cnt >= lat));

    always @(posedge clk or negedge rst) begin
        if (!rst)                     wait_cnt <= 0;
        else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                          wait_cnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset over one edge and releases it 1ns after an edge, so the
    // next edge is the first cycle out of reset.
    task automatic apply_reset();
        stall = 1'b0; branch_taken = 1'b0; branch_addr = 9'd0; force_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        stall = 1'b0; branch_taken = 1'b0; branch_addr = 9'd0; force_ready = 1'b0; lat = 0;
        rst = 1'b0;
        #3;
        checks++; if (pc !== 9'd0) begin errors++; $display("FAIL rst_pc: got %0d want 0", pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if (line_data !== 16'h0000) begin errors++; $display("FAIL rst_line: got %h want 0000", line_data); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 9'd0) begin errors++; $display("FAIL rst_first_req: got req=%b addr=%0d want req=1 addr=0", mem_req, mem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [15:0] exp_line [3];
        exp_line[0] = 16'h0801; exp_line[1] = 16'h0C05; exp_line[2] = 16'h2803;
        lat = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid%0d: got %b want 1", i, instr_valid); end
            checks++; if (line_data !== exp_line[i]) begin errors++; $display("FAIL zw_line%0d: got %h want %h", i, line_data, exp_line[i]); end
            checks++; if (pc !== 9'(i + 1)) begin errors++; $display("FAIL zw_pc%0d: got %0d want %0d", i, pc, i + 1); end
        end
    endtask

    task automatic test_wait_states();
        lat = 3;
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || mem_addr !== 9'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL ws_wait%0d: got req=%b addr=%0d valid=%b want 1/0/0", i, mem_req, mem_addr, instr_valid); end
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || line_data !== 16'h0801 || pc !== 9'd1) begin errors++; $display("FAIL ws_cap0: got valid=%b line=%h pc=%0d want 1/0801/1", instr_valid, line_data, pc); end
        tick();
        checks++; if (instr_valid !== 1'b0 || pc !== 9'd1 || mem_addr !== 9'd1 || mem_req !== 1'b1) begin errors++; $display("FAIL ws_pulse: got valid=%b pc=%0d addr=%0d req=%b want 0/1/1/1", instr_valid, pc, mem_addr, mem_req); end
        tick(); tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ws_early: got valid=%b want 0", instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1 || line_data !== 16'h0C05 || pc !== 9'd2) begin errors++; $display("FAIL ws_cap1: got valid=%b line=%h pc=%0d want 1/0C05/2", instr_valid, line_data, pc); end
    endtask

    task automatic test_stall();
        lat = 0;
        apply_reset();
        tick();
        stall = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (line_data !== 16'h0801 || pc !== 9'd1 || instr_valid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL st_hold%0d: got line=%h pc=%0d valid=%b req=%b want 0801/1/1/0", i, line_data, pc, instr_valid, mem_req); end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL st_release_req: got %b want 1", mem_req); end
        tick();
        checks++; if (line_data !== 16'h0C05 || pc !== 9'd2 || instr_valid !== 1'b1) begin errors++; $display("FAIL st_next: got line=%h pc=%0d valid=%b want 0C05/2/1", line_data, pc, instr_valid); end
    endtask

    task automatic test_branch();
        lat = 0;
        apply_reset();
        tick();
        branch_taken = 1'b1; branch_addr = 9'd100; force_ready = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL br_req: got %b want 0", mem_req); end
        tick();
        branch_taken = 1'b0; force_ready = 1'b0;
        #1;
        checks++; if (pc !== 9'd100 || instr_valid !== 1'b0 || line_data !== 16'h0000) begin errors++; $display("FAIL br_redirect: got pc=%0d valid=%b line=%h want 100/0/0000", pc, instr_valid, line_data); end
        checks++; if (mem_addr !== 9'd100 || mem_req !== 1'b1) begin errors++; $display("FAIL br_next_addr: got addr=%0d req=%b want 100/1", mem_addr, mem_req); end
        tick();
        checks++; if (line_data !== 16'h1234 || pc !== 9'd101) begin errors++; $display("FAIL br_fetch: got line=%h pc=%0d want 1234/101", line_data, pc); end
        // redirect to the current pc refetches that address
        branch_taken = 1'b1; branch_addr = 9'd101;
        tick();
        branch_taken = 1'b0;
        checks++; if (pc !== 9'd101 || instr_valid !== 1'b0) begin errors++; $display("FAIL br_same_pc: got pc=%0d valid=%b want 101/0", pc, instr_valid); end
        tick();
        checks++; if (line_data !== 16'h2345 || pc !== 9'd102) begin errors++; $display("FAIL br_refetch: got line=%h pc=%0d want 2345/102", line_data, pc); end
    endtask

    task automatic test_halt();
        lat = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) tick();
        checks++; if (pc !== 9'd5 || line_data !== 16'h1111) begin errors++; $display("FAIL ht_pre: got pc=%0d line=%h want 5/1111", pc, line_data); end
        tick();
        checks++; if (halted !== 1'b1 || pc !== 9'd5 || instr_valid !== 1'b0 || line_data !== 16'h1111) begin errors++; $display("FAIL ht_enter: got halted=%b pc=%0d valid=%b line=%h want 1/5/0/1111", halted, pc, instr_valid, line_data); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 9'd5) begin errors++; $display("FAIL ht_hold%0d: got halted=%b req=%b valid=%b pc=%0d want 1/0/0/5", i, halted, mem_req, instr_valid, pc); end
        end
        branch_taken = 1'b1; branch_addr = 9'd0;
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || pc !== 9'd0 || mem_req !== 1'b1) begin errors++; $display("FAIL ht_resume: got halted=%b pc=%0d req=%b want 0/0/1", halted, pc, mem_req); end
        tick();
        checks++; if (line_data !== 16'h0801 || pc !== 9'd1 || instr_valid !== 1'b1) begin errors++; $display("FAIL ht_refetch: got line=%h pc=%0d valid=%b want 0801/1/1", line_data, pc, instr_valid); end
        // run back into the halt word, then reset while halted
        for (int i = 0; i < 5; i++) tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ht_reenter: got %b want 1", halted); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || pc !== 9'd0 || mem_req !== 1'b0) begin errors++; $display("FAIL ht_reset: got halted=%b pc=%0d req=%b want 0/0/0", halted, pc, mem_req); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_wrap_and_reset();
        lat = 0;
        apply_reset();
        branch_taken = 1'b1; branch_addr = 9'd511;
        tick();
        branch_taken = 1'b0;
        checks++; if (pc !== 9'd511) begin errors++; $display("FAIL wr_pc511: got %0d want 511", pc); end
        tick();
        checks++; if (pc !== 9'd0 || line_data !== 16'h3333 || instr_valid !== 1'b1) begin errors++; $display("FAIL wr_wrap: got pc=%0d line=%h valid=%b want 0/3333/1", pc, line_data, instr_valid); end
        // reset in the middle of a waiting read
        lat = 3;
        tick(); tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 9'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL wr_midwait: got req=%b addr=%0d valid=%b want 1/0/0", mem_req, mem_addr, instr_valid); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (pc !== 9'd0 || line_data !== 16'h0000 || instr_valid !== 1'b0 || halted !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL wr_async_rst: got pc=%0d line=%h valid=%b halted=%b req=%b want 0/0000/0/0/0", pc, line_data, instr_valid, halted, mem_req); end
        tick();
        rst = 1'b1;
        lat = 0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 9'd0) begin errors++; $display("FAIL wr_restart_req: got req=%b addr=%0d want 1/0", mem_req, mem_addr); end
        tick();
        checks++; if (line_data !== 16'h0801 || pc !== 9'd1) begin errors++; $display("FAIL wr_restart: got line=%h pc=%0d want 0801/1", line_data, pc); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h0801;
        mem[1]   = 16'h0C05;
        mem[2]   = 16'h2803;
        mem[3]   = 16'h1000;
        mem[4]   = 16'h1111;
        mem[5]   = 16'hFC00;
        mem[100] = 16'h1234;
        mem[101] = 16'h2345;
        mem[511] = 16'h3333;
        lat = 0;
        force_ready = 1'b0;

        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch();
        test_halt();
        test_wrap_and_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
